// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the RAM command front-end: op codes, FSM state
// encoding and default geometry of the 32x32 lab RAM.
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_CLR      = 3'd4
  } state_t;

endpackage

// File: rtl/ram_cmd_ctrl.sv
// Command front-end for the single-port synchronous RAM: turns write/read/clear
// commands into registered RAM pin activity and returns read data.
module ram_cmd_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              clr_done,
  output logic              busy,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t state;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // Reads keep ena high through RD_WAIT so the RAM output stays driven until captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ram_ena   <= 1'b0;
      ram_wena  <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      clr_done  <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_WRITE: begin
                ram_ena   <= 1'b1;
                ram_wena  <= 1'b1;
                ram_addr  <= cmd_addr;
                ram_wdata <= cmd_wdata;
                state     <= ST_WR;
              end
              OP_READ: begin
                ram_ena  <= 1'b1;
                ram_wena <= 1'b0;
                ram_addr <= cmd_addr;
                state    <= ST_RD_ISSUE;
              end
              OP_CLEAR: begin
                ram_ena   <= 1'b1;
                ram_wena  <= 1'b1;
                ram_addr  <= '0;
                ram_wdata <= CLEAR_VAL;
                state     <= ST_CLR;
              end
              default: ;
            endcase
          end
        end
        ST_WR: begin
          ram_ena  <= 1'b0;
          ram_wena <= 1'b0;
          state    <= ST_IDLE;
        end
        ST_RD_ISSUE: begin
          state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          rd_data  <= ram_rdata;
          rd_valid <= 1'b1;
          ram_ena  <= 1'b0;
          state    <= ST_IDLE;
        end
        ST_CLR: begin
          if (ram_addr != LAST_ADDR) begin
            ram_addr <= ram_addr + 1'b1;
          end else begin
            ram_ena  <= 1'b0;
            ram_wena <= 1'b0;
            clr_done <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          ram_ena  <= 1'b0;
          ram_wena <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// Self-checking bench for ram_cmd_ctrl with a behavioural 32x32 RAM behind the
// ram_* pins and a scoreboard of expected read results.
module tb_ram_cmd_ctrl;

  localparam logic [1:0] OPC_NOP   = 2'b00;
  localparam logic [1:0] OPC_WRITE = 2'b01;
  localparam logic [1:0] OPC_READ  = 2'b10;
  localparam logic [1:0] OPC_CLEAR = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        clr_done;
  logic        busy;
  logic        ram_ena;
  logic        ram_wena;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  ram_cmd_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .clr_done(clr_done), .busy(busy),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Behavioural single-port RAM with registered data_out.
  logic [31:0] mem [32];
  logic [31:0] ram_dout;
  always @(posedge clk) begin
    if (ram_ena) begin
      if (ram_wena) mem[ram_addr] <= ram_wdata;
      else          ram_dout      <= mem[ram_addr];
    end
  end
  assign ram_rdata = ram_dout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] shadow [32];
  logic [31:0] last_rd = '0;
  int          checks = 0;
  int          errors = 0;
  int          clr_cnt = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one command, waits (bounded) for acceptance and updates the model.
  task automatic apply_stimulus(input logic [1:0] op, input logic [4:0] addr,
                                input logic [31:0] data, input bit hold, output int acc);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = data;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("accept_timeout", 32'(n < 200), 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    case (op)
      OPC_WRITE: shadow[addr] = data;
      OPC_READ: begin
        e.data = shadow[addr];
        e.due  = cyc + 2;
        sb.push_back(e);
      end
      OPC_CLEAR: for (int i = 0; i < 32; i++) shadow[i] = '0;
      default: ;
    endcase
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Read-side monitor: pops the scoreboard on every rd_valid and checks hold otherwise.
  initial begin
    exp_t e;
    bit   prev_rv;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rd_valid) begin
          check_output("rd_valid_expected", 32'(sb.size() != 0), 32'd1);
          check_output("rd_valid_width", 32'(prev_rv), 32'd0);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check_output("rd_latency", 32'(cyc), 32'(e.due));
            check_output("rd_data", rd_data, e.data);
            last_rd = e.data;
          end
        end else begin
          check_output("rd_data_hold", rd_data, last_rd);
        end
        prev_rv = rd_valid;
        if (clr_done) clr_cnt++;
      end else begin
        prev_rv = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, acc2, n, idx, c0, cnt_before;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OPC_NOP;
    cmd_addr  = '0;
    cmd_wdata = '0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;

    // Reset state
    #12;
    check_output("rst_ram_ena", 32'(ram_ena), 32'd0);
    check_output("rst_ram_wena", 32'(ram_wena), 32'd0);
    check_output("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_output("rst_ram_wdata", ram_wdata, 32'd0);
    check_output("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_output("rst_rd_data", rd_data, 32'd0);
    check_output("rst_clr_done", 32'(clr_done), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_output("idle_ram_ena", 32'(ram_ena), 32'd0);
    check_output("idle_busy", 32'(busy), 32'd0);
    check_output("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check_output("idle_clr_cnt", 32'(clr_cnt), 32'd0);

    // Write then read address 5, with occupancy of each
    apply_stimulus(OPC_WRITE, 5'd5, 32'hDEADBEEF, 1'b0, acc);
    check_output("wr_ram_ena", 32'(ram_ena), 32'd1);
    check_output("wr_ram_wena", 32'(ram_wena), 32'd1);
    check_output("wr_ram_addr", 32'(ram_addr), 32'd5);
    check_output("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
    wait_ready(n);
    check_output("wr_ready_low", 32'(n), 32'd1);
    apply_stimulus(OPC_READ, 5'd5, '0, 1'b0, acc);
    check_output("rd_ram_wena", 32'(ram_wena), 32'd0);
    wait_ready(n);
    check_output("rd_ready_low", 32'(n), 32'd2);
    drain();

    // Back-to-back writes at both address boundaries with cmd_valid held
    apply_stimulus(OPC_WRITE, 5'd31, 32'h1, 1'b1, acc);
    apply_stimulus(OPC_WRITE, 5'd0, 32'h2, 1'b0, acc2);
    check_output("b2b_spacing", 32'(acc2 - acc), 32'd2);
    apply_stimulus(OPC_READ, 5'd31, '0, 1'b0, acc);
    apply_stimulus(OPC_READ, 5'd0, '0, 1'b0, acc);
    drain();

    // Fill with ones, clear, then read everything back
    for (int i = 0; i < 32; i++) apply_stimulus(OPC_WRITE, 5'(i), 32'hFFFFFFFF, 1'b0, acc);
    cnt_before = clr_cnt;
    apply_stimulus(OPC_CLEAR, '0, '0, 1'b0, acc);
    n   = 0;
    idx = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      check_output("clr_addr_seq", 32'(ram_addr), 32'(idx));
      check_output("clr_ram_ena", 32'(ram_ena), 32'd1);
      idx++;
      n++;
      @(negedge clk);
    end
    check_output("clr_busy_cycles", 32'(n), 32'd32);
    check_output("clr_done_pulse", 32'(clr_done), 32'd1);
    check_output("clr_end_ena", 32'(ram_ena), 32'd0);
    @(negedge clk);
    check_output("clr_done_width", 32'(clr_done), 32'd0);
    #1;
    check_output("clr_done_count", 32'(clr_cnt - cnt_before), 32'd1);
    for (int i = 0; i < 32; i++) apply_stimulus(OPC_READ, 5'(i), '0, 1'b0, acc);
    drain();

    // Commands presented while busy wait for IDLE; rd_data holds meanwhile
    apply_stimulus(OPC_WRITE, 5'd7, 32'hA5A5A5A5, 1'b0, acc);
    apply_stimulus(OPC_READ, 5'd7, '0, 1'b0, acc);
    drain();
    apply_stimulus(OPC_CLEAR, '0, '0, 1'b1, c0);
    apply_stimulus(OPC_NOP, '0, '0, 1'b1, acc);
    check_output("busy_nop_accept", 32'(acc - c0), 32'd33);
    apply_stimulus(OPC_READ, 5'd7, '0, 1'b0, acc2);
    check_output("busy_read_accept", 32'(acc2 - c0), 32'd34);
    drain();

    // Distinct pattern, then reset in the middle of a clear at ram_addr 10
    for (int i = 0; i < 32; i++) apply_stimulus(OPC_WRITE, 5'(i), 32'hC0DE0000 + 32'(i), 1'b0, acc);
    cnt_before = clr_cnt;
    apply_stimulus(OPC_CLEAR, '0, '0, 1'b0, acc);
    n = 0;
    while (ram_addr != 5'd10 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output("abort_reach_addr10", 32'(ram_addr), 32'd10);
    rst_n = 1'b0;
    #1;
    last_rd = '0;
    check_output("abort_ram_ena", 32'(ram_ena), 32'd0);
    check_output("abort_ram_wena", 32'(ram_wena), 32'd0);
    check_output("abort_ram_addr", 32'(ram_addr), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_output("abort_no_clr_done", 32'(clr_cnt - cnt_before), 32'd0);
    for (int i = 10; i < 32; i++) shadow[i] = 32'hC0DE0000 + 32'(i);
    for (int i = 0; i < 32; i++) apply_stimulus(OPC_READ, 5'(i), '0, 1'b0, acc);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
